mask_pattern_streamer: RTL
==========================

Name: mask_pattern_streamer

Overview:
- Pattern-memory stage directly downstream of the exposure/mask-preload FSM.
- Holds up to C_NUM_PATT mask patterns of C_NUM_ROWS rows each, loaded by the host over a word-wide write port.
- During each STREAM burst from the FSM, reads out one row per CLKMPRE cycle and drives it to the chip mask-data pins.
- Advances to the next pattern per burst, wraps after the active pattern count, and flags malformed bursts.

Parameters:
C_NUM_PATT, 100, maximum stored patterns
C_NUM_ROWS, 160, rows per pattern (one STREAM cycle per row)
C_MASK_W, 18, mask bits per row word (chip deserialization factor)
C_PAT_W, 16, width of PAT_IDX
C_ROW_W, 8, width of ROW_IDX (must hold C_NUM_ROWS)

Ports:
CLKMPRE  in  1  mask preload clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
STREAM  in  1  from FSM; high = stream one row this cycle
PAT_RESTART  in  1  single-cycle pulse: rewind to pattern 0, re-sample Num_Pat
Num_Pat  in  32  active pattern count
WR_ADDR_RST  in  1  host: rewind write pointer, clear LOAD_DONE
WR_EN  in  1  host: write WR_DATA at write pointer
WR_DATA  in  C_MASK_W  host row word
LOAD_DONE  out  1  full set of npat_eff patterns written
MASK_DATA  out  C_MASK_W  row word to chip
MASK_VALID  out  1  MASK_DATA carries a streamed row
PAT_IDX  out  C_PAT_W  current read pattern
ROW_IDX  out  C_ROW_W  next read row within pattern
ERR_ROWCNT  out  1  sticky malformed-burst flag

Behaviour:
- Reset is synchronous, active-high on RESET, clock is CLKMPRE.
- RESET response: all outputs 0; read pointers 0; write pointer 0; stream_d 0; npat_eff = clamp(Num_Pat).
- Memory contents are not cleared by RESET.
- clamp(x): 0 -> 1; x > C_NUM_PATT -> C_NUM_PATT; otherwise x.
- npat_eff is updated only at RESET and PAT_RESTART. Num_Pat changes at any other time are ignored.
- Memory: C_NUM_PATT*C_NUM_ROWS words of C_MASK_W bits, simple dual-port (block RAM).
- Read address = PAT_IDX*C_NUM_ROWS + ROW_IDX.
- Streaming:
  - Cycle with STREAM=1 and ROW_IDX<C_NUM_ROWS: issue a read and increment ROW_IDX.
  - One cycle later: MASK_DATA = word and MASK_VALID = 1. Latency is exactly 1 cycle.
- Overlong burst: STREAM=1 with ROW_IDX==C_NUM_ROWS means no read. The next cycle gives MASK_VALID=0 and MASK_DATA=0. ERR_ROWCNT is set and ROW_IDX holds.
- Outside a valid read: MASK_DATA=0, MASK_VALID=0.
- Burst end is the cycle where STREAM=0 and stream_d=1:
  - If ROW_IDX != C_NUM_ROWS, set ERR_ROWCNT.
  - ROW_IDX <= 0.
  - PAT_IDX <= (PAT_IDX+1 == npat_eff) ? 0 : PAT_IDX+1.
- PAT_RESTART has priority over burst end and streaming:
  - PAT_IDX <= 0, ROW_IDX <= 0, npat_eff re-sampled.
  - If STREAM or stream_d is high in that cycle, set ERR_ROWCNT (aborted burst); no read is issued that cycle.
- ERR_ROWCNT is cleared only by RESET.
- Write port:
  - WR_ADDR_RST=1: wr_ptr <= 0, LOAD_DONE <= 0. Any WR_EN in the same cycle is discarded.
  - Otherwise WR_EN=1: mem[wr_ptr] <= WR_DATA.
  - If wr_ptr == npat_eff*C_NUM_ROWS-1: wr_ptr <= 0 and LOAD_DONE <= 1. Else wr_ptr+1.
- Read/write to the same address in the same cycle returns the old data (read-first).
- Writes are permitted during streaming; no stall.
- Internal state is IDLE/STREAMING/ABORT-free: behaviour is fully defined by stream_d, ROW_IDX and PAT_IDX as above.
- Recovery: any ROW_IDX>C_NUM_ROWS or PAT_IDX>=npat_eff forces both to 0 on the next cycle and sets ERR_ROWCNT.

Test Plan:
1. Reset, Num_Pat=3; WR_ADDR_RST, then 480 writes of data=address -> LOAD_DONE rises on the 480th write; wr_ptr wraps to 0.
2. After load, three 160-cycle STREAM bursts separated by 2 idle cycles -> MASK_VALID high 160 cycles per burst, 1 cycle after STREAM. MASK_DATA = 0..159, 160..319, 320..479. PAT_IDX goes 0->1->2->0. ERR_ROWCNT stays 0.
3. STREAM burst of 150 cycles -> ERR_ROWCNT=1 after the burst end; PAT_IDX advances; the next 160-cycle burst still streams the correct pattern.
4. STREAM burst of 165 cycles -> last 5 output cycles have MASK_VALID=0 and MASK_DATA=0; ERR_ROWCNT=1; ROW_IDX holds at 160 until the burst ends.
5. PAT_RESTART at row 80 of pattern 1 with Num_Pat changed to 2 -> PAT_IDX=0, ROW_IDX=0, ERR_ROWCNT=1; following bursts alternate patterns 0,1.
6. Num_Pat=0 and Num_Pat=500 at RESET -> npat_eff=1 (PAT_IDX stays 0) and npat_eff=100 respectively. WR_ADDR_RST together with WR_EN -> write discarded, wr_ptr=0.

Source files
------------

// File: rtl/mask_pattern_streamer_if.sv
// Signal bundle between the exposure FSM / host and the mask pattern streamer.
// The master side drives stream control and the host write port; the slave side returns mask data and status.
interface mask_pattern_streamer_if #(
  parameter int C_MASK_W = 18,
  parameter int C_PAT_W  = 16,
  parameter int C_ROW_W  = 8
);
  logic                STREAM;
  logic                PAT_RESTART;
  logic [31:0]         Num_Pat;
  logic                WR_ADDR_RST;
  logic                WR_EN;
  logic [C_MASK_W-1:0] WR_DATA;
  logic                LOAD_DONE;
  logic [C_MASK_W-1:0] MASK_DATA;
  logic                MASK_VALID;
  logic [C_PAT_W-1:0]  PAT_IDX;
  logic [C_ROW_W-1:0]  ROW_IDX;
  logic                ERR_ROWCNT;

  modport master (
    output STREAM, PAT_RESTART, Num_Pat, WR_ADDR_RST, WR_EN, WR_DATA,
    input  LOAD_DONE, MASK_DATA, MASK_VALID, PAT_IDX, ROW_IDX, ERR_ROWCNT
  );

  modport slave (
    input  STREAM, PAT_RESTART, Num_Pat, WR_ADDR_RST, WR_EN, WR_DATA,
    output LOAD_DONE, MASK_DATA, MASK_VALID, PAT_IDX, ROW_IDX, ERR_ROWCNT
  );
endinterface

// File: rtl/mask_pattern_streamer.sv
// Pattern memory behind the mask-preload FSM: the host loads row words, and each STREAM burst
// plays one pattern out row by row, advancing patterns per burst and flagging malformed bursts.
module mask_pattern_streamer #(
  parameter int C_NUM_PATT = 100,
  parameter int C_NUM_ROWS = 160,
  parameter int C_MASK_W   = 18,
  parameter int C_PAT_W    = 16,
  parameter int C_ROW_W    = 8
) (
  input logic                    CLKMPRE,
  input logic                    RESET,
  mask_pattern_streamer_if.slave bus
);
  localparam int C_DEPTH  = C_NUM_PATT * C_NUM_ROWS;
  localparam int C_ADDR_W = $clog2(C_DEPTH);

  logic [C_MASK_W-1:0] mem [C_DEPTH];
  logic [C_MASK_W-1:0] rd_word;
  logic [C_ADDR_W-1:0] rd_addr;
  logic [C_ADDR_W-1:0] wr_ptr;
  logic [31:0]         wr_last;
  logic [C_PAT_W-1:0]  npat_eff;
  logic [C_PAT_W-1:0]  npat_req;
  logic [C_PAT_W-1:0]  pat_idx;
  logic [C_PAT_W-1:0]  pat_next;
  logic [C_ROW_W-1:0]  row_idx;
  logic                stream_d;
  logic                mask_valid;
  logic                err_rowcnt;
  logic                load_done;
  logic                burst_end;
  logic                out_of_range;
  logic                rd_en;
  logic                overlong;
  logic                wr_fire;
  logic                wr_wrap;

  function automatic logic [C_PAT_W-1:0] clamp_npat(input logic [31:0] x);
    logic [C_PAT_W-1:0] r;
    if (x == 32'd0)
      r = C_PAT_W'(1);
    else if (x > 32'(C_NUM_PATT))
      r = C_PAT_W'(C_NUM_PATT);
    else
      r = x[C_PAT_W-1:0];
    return r;
  endfunction

  always_comb begin
    npat_req     = clamp_npat(bus.Num_Pat);
    burst_end    = !bus.STREAM && stream_d;
    out_of_range = (row_idx > C_ROW_W'(C_NUM_ROWS)) || (pat_idx >= npat_eff);
    rd_en        = bus.STREAM && !bus.PAT_RESTART && !out_of_range &&
                   (row_idx < C_ROW_W'(C_NUM_ROWS));
    overlong     = bus.STREAM && !bus.PAT_RESTART && !out_of_range &&
                   (row_idx == C_ROW_W'(C_NUM_ROWS));
    pat_next     = ((pat_idx + C_PAT_W'(1)) == npat_eff) ? '0 : pat_idx + C_PAT_W'(1);
    rd_addr      = C_ADDR_W'(pat_idx) * C_ADDR_W'(C_NUM_ROWS) + C_ADDR_W'(row_idx);
    wr_fire      = bus.WR_EN && !bus.WR_ADDR_RST;
    wr_last      = 32'(npat_eff) * 32'(C_NUM_ROWS) - 32'd1;
    // >= rather than == so a pointer left beyond a shrunken pattern set still wraps
    wr_wrap      = 32'(wr_ptr) >= wr_last;
  end

  // Read-first block RAM; the output word is masked by mask_valid instead of being reset.
  always_ff @(posedge CLKMPRE) begin
    if (wr_fire)
      mem[wr_ptr] <= bus.WR_DATA;
    rd_word <= mem[rd_addr];
  end

  always_ff @(posedge CLKMPRE) begin
    if (RESET) begin
      pat_idx    <= '0;
      row_idx    <= '0;
      stream_d   <= 1'b0;
      mask_valid <= 1'b0;
      err_rowcnt <= 1'b0;
      npat_eff   <= npat_req;
      wr_ptr     <= '0;
      load_done  <= 1'b0;
    end else begin
      stream_d   <= bus.STREAM;
      mask_valid <= rd_en;

      if (bus.PAT_RESTART) begin
        pat_idx  <= '0;
        row_idx  <= '0;
        npat_eff <= npat_req;
        if (bus.STREAM || stream_d)
          err_rowcnt <= 1'b1;
      end else if (out_of_range) begin
        pat_idx    <= '0;
        row_idx    <= '0;
        err_rowcnt <= 1'b1;
      end else if (burst_end) begin
        if (row_idx != C_ROW_W'(C_NUM_ROWS))
          err_rowcnt <= 1'b1;
        row_idx <= '0;
        pat_idx <= pat_next;
      end else if (rd_en) begin
        row_idx <= row_idx + C_ROW_W'(1);
      end else if (overlong) begin
        err_rowcnt <= 1'b1;
      end

      if (bus.WR_ADDR_RST) begin
        wr_ptr    <= '0;
        load_done <= 1'b0;
      end else if (bus.WR_EN) begin
        if (wr_wrap) begin
          wr_ptr    <= '0;
          load_done <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + C_ADDR_W'(1);
        end
      end
    end
  end

  assign bus.MASK_DATA  = mask_valid ? rd_word : '0;
  assign bus.MASK_VALID = mask_valid;
  assign bus.PAT_IDX    = pat_idx;
  assign bus.ROW_IDX    = row_idx;
  assign bus.ERR_ROWCNT = err_rowcnt;
  assign bus.LOAD_DONE  = load_done;
endmodule
